// File: rtl/tt_lut_pkg.sv
// Shared types and sizing helpers for the truth-table engine.
package tt_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  function automatic int nchunk(input int tt_w, input int cfg_w);
    return (tt_w + cfg_w - 1) / cfg_w;
  endfunction

  // Chunk counter width; never below one bit even for a single-chunk table.
  function automatic int chunk_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_lut_cfg_loader.sv
// Shadow table assembly from config chunks; raises a registered swap strobe
// one cycle after the final chunk is written.
module tt_lut_cfg_loader import tt_lut_pkg::*; #(
  parameter int TT_W  = 16,
  parameter int CFG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CFG_W-1:0] cfg_data,
  output logic [TT_W-1:0]  shadow,
  output logic             last,
  output logic             swap
);

  localparam int NCHUNK = nchunk(TT_W, CFG_W);
  localparam int CIW    = chunk_idx_w(NCHUNK);

  logic [CIW-1:0]  chunk_reg;
  logic [TT_W-1:0] shadow_reg;
  logic            swap_reg;
  logic [TT_W-1:0] wr_mask;
  logic [TT_W-1:0] wr_bits;

  assign last = wr && (chunk_reg == CIW'(NCHUNK - 1));

  // Each table bit belongs to exactly one chunk; bits past TT_W in the last chunk have no home.
  for (genvar gi = 0; gi < TT_W; gi++) begin : g_bit
    assign wr_mask[gi] = wr && (chunk_reg == CIW'(gi / CFG_W));
    assign wr_bits[gi] = cfg_data[gi % CFG_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chunk_reg  <= '0;
      shadow_reg <= '0;
      swap_reg   <= 1'b0;
    end else begin
      shadow_reg <= (shadow_reg & ~wr_mask) | (wr_bits & wr_mask);
      swap_reg   <= last;
      if (last) begin
        chunk_reg <= '0;
      end else if (wr) begin
        chunk_reg <= chunk_reg + 1'b1;
      end
    end
  end

  assign shadow = shadow_reg;
  assign swap   = swap_reg;

endmodule

// File: rtl/tt_lut_engine.sv
// Runtime-programmable N-input truth-table evaluator with a one-deep output stage.
// Define TT_SWEEP_EN to build the exhaustive sweep mode.
module tt_lut_engine import tt_lut_pkg::*; #(
  parameter int                   N_IN       = 4,
  parameter logic [(1<<N_IN)-1:0] TT_DEFAULT = 16'h1FDE,
  parameter int                   CFG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  input  logic             sweep_start,
  output logic             sweep_last
);

  localparam int TT_W = 1 << N_IN;

  state_t          state_reg;
  state_t          state_next;
  logic [TT_W-1:0] active_reg;
  logic [TT_W-1:0] shadow;
  logic            last_fire;
  logic            swap;
  logic            out_valid_reg;
  logic            out_bit_reg;
  logic            slot_free;
  logic            in_fire;
  logic            load_out;
  logic            load_bit;

`ifdef TT_SWEEP_EN
  logic [N_IN-1:0] sweep_cnt_reg;
  logic            sweep_last_reg;
`else
  logic            unused_sweep_start;
  assign unused_sweep_start = sweep_start;
`endif

  assign slot_free = !out_valid_reg || out_ready;
  assign in_ready  = rst_n && (state_reg != ST_SWEEP) && slot_free;
  assign in_fire   = in_valid && in_ready;

  tt_lut_cfg_loader #(
    .TT_W  (TT_W),
    .CFG_W (CFG_W)
  ) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (cfg_valid && cfg_ready),
    .cfg_data (cfg_data),
    .shadow   (shadow),
    .last     (last_fire),
    .swap     (swap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cfg_ready  = 1'b0;
    load_out   = in_fire;
    load_bit   = active_reg[in_vec];
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next = ST_LOAD;
`ifdef TT_SWEEP_EN
        end else if (sweep_start) begin
          state_next = ST_SWEEP;
`endif
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (last_fire) begin
          state_next = ST_IDLE;
        end
      end
`ifdef TT_SWEEP_EN
      ST_SWEEP: begin
        // Stop issuing once the final index is sitting in the output register.
        load_out = slot_free && !sweep_last_reg;
        load_bit = active_reg[sweep_cnt_reg];
        if (sweep_last_reg && out_valid_reg && out_ready) begin
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // The swap lands one edge after the last chunk, so the vector taken in the
  // cfg_done cycle still sees the old table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_reg <= TT_DEFAULT;
    end else if (swap) begin
      active_reg <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_bit_reg   <= 1'b0;
    end else if (load_out) begin
      out_valid_reg <= 1'b1;
      out_bit_reg   <= load_bit;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifdef TT_SWEEP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweep_cnt_reg  <= '0;
      sweep_last_reg <= 1'b0;
    end else begin
      if (state_reg == ST_SWEEP && load_out) begin
        sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
      end
      if (load_out) begin
        sweep_last_reg <= (state_reg == ST_SWEEP) && (sweep_cnt_reg == N_IN'(TT_W - 1));
      end else if (out_ready) begin
        sweep_last_reg <= 1'b0;
      end
    end
  end
  assign sweep_last = sweep_last_reg;
`else
  assign sweep_last = 1'b0;
`endif

  assign cfg_done  = swap;
  assign out_valid = out_valid_reg;
  assign out_bit   = out_bit_reg;

endmodule

// File: tb/tb_tt_lut_engine.sv
// Directed self-checking bench for tt_lut_engine (default 4-input, 8-bit chunk build).
module tb_tt_lut_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready;
  logic       cfg_done;
  logic       in_valid = 1'b0;
  logic [3:0] in_vec = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_ready = 1'b0;
  logic       sweep_start = 1'b0;
  logic       sweep_last;

  int total = 0;
  int passed = 0;

  logic [15:0] tt_exp;
  logic [3:0]  vecs [4] = '{4'd0, 4'd1, 4'd12, 4'd15};
  logic        bits [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  tt_lut_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .out_ready   (out_ready),
    .sweep_start (sweep_start),
    .sweep_last  (sweep_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input logic [15:0] tt);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("load_ready", cfg_ready, 1'b1);
    cfg_valid = 1'b1;
    cfg_data  = tt[7:0];
    tick();
    chk("load_done_early", cfg_done, 1'b0);
    cfg_data = tt[15:8];
    tick();
    cfg_valid = 1'b0;
    chk("load_done", cfg_done, 1'b1);
    tick();
    chk("load_done_clr", cfg_done, 1'b0);
  endtask

  task automatic eval1(input string tag, input logic [3:0] v, input logic exp);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    chk({tag, "_v"}, out_valid, 1'b1);
    chk(tag, out_bit, exp);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bit", out_bit, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_sweep_last", sweep_last, 1'b0);

    // Back-to-back evaluation on the reset table 0x1FDE
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = vecs[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("b2b_bit%0d", i), out_bit, bits[i]);
      if (i < 3) in_vec = vecs[i + 1];
      else in_valid = 1'b0;
    end
    tick();
    chk("b2b_drain", out_valid, 1'b0);

    // Stream vector 15 while loading 0x8001 (old bit15=0, new bit15=1)
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 4'd15;
    tick();
    cfg_start = 1'b0;
    chk("ld_ready", cfg_ready, 1'b1);
    chk("ld_s1_bit", out_bit, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 8'h01;
    tick();
    chk("ld_s2_bit", out_bit, 1'b0);
    chk("ld_s2_done", cfg_done, 1'b0);
    cfg_data = 8'h80;
    tick();
    cfg_valid = 1'b0;
    chk("ld_s3_done", cfg_done, 1'b1);
    chk("ld_s3_ready", cfg_ready, 1'b0);
    chk("ld_s3_bit", out_bit, 1'b0);
    tick();
    chk("ld_swap_bit_old", out_bit, 1'b0);
    chk("ld_s4_done", cfg_done, 1'b0);
    tick();
    chk("ld_next_bit_new", out_bit, 1'b1);
    chk("ld_next_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();

    // Evaluate the new table 0x8001
    eval1("t8001_v0", 4'd0, 1'b1);
    eval1("t8001_v15", 4'd15, 1'b1);
    eval1("t8001_v1", 4'd1, 1'b0);
    tick();

    // Backpressure: result held for 3 cycles, then released
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'd0;
    tick();
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_bit", out_bit, 1'b1);
    in_vec = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
      chk($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("bp_hold_bit%0d", i), out_bit, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_bit", out_bit, 1'b0);
    tick();
    chk("bp_no_dup", out_valid, 1'b0);

    // Reset in the middle of a load
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'h55;
    tick();
    cfg_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    chk("mid_rst_done", cfg_done, 1'b0);
    chk("mid_rst_ready", cfg_ready, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_done2", cfg_done, 1'b0);
    tt_exp   = 16'h1FDE;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_vec = 4'(i);
      tick();
      chk($sformatf("readback%0d", i), out_bit, tt_exp[i]);
      chk($sformatf("readback_done%0d", i), cfg_done, 1'b0);
    end
    in_valid = 1'b0;
    tick();

    // Fresh load after the aborted one must start from chunk 0
    load_table(16'h3CA5);
    eval1("t3ca5_v0", 4'd0, 1'b1);
    eval1("t3ca5_v1", 4'd1, 1'b0);
    eval1("t3ca5_v13", 4'd13, 1'b1);
    eval1("t3ca5_v15", 4'd15, 1'b0);
    tick();

    // Back to the default table for the sweep section
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
`ifdef TT_SWEEP_EN
    begin
      int k;
      k = 0;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      chk("sweep_in_ready", in_ready, 1'b0);
      for (int cyc = 0; cyc < 40 && k < 16; cyc++) begin
        tick();
        if (out_valid) begin
          chk($sformatf("sweep_bit%0d", k), out_bit, tt_exp[k]);
          chk($sformatf("sweep_last%0d", k), sweep_last, (k == 15));
          k++;
        end
      end
      chk("sweep_count", 16'(k), 16'd16);
      tick();
      chk("sweep_end_valid", out_valid, 1'b0);
      chk("sweep_end_ready", in_ready, 1'b1);
      chk("sweep_end_last", sweep_last, 1'b0);
    end
`else
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("nosweep_ready", in_ready, 1'b1);
    chk("nosweep_valid", out_valid, 1'b0);
    chk("nosweep_last", sweep_last, 1'b0);
    tick();
    chk("nosweep_ready2", in_ready, 1'b1);
    chk("nosweep_valid2", out_valid, 1'b0);
    eval1("nosweep_v12", 4'd12, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
